// File: rtl/seg7_number_display.sv
// N-digit seven-segment number engine: sequential double-dabble decimal or raw hex, blanking, sign, active-low segments.
// Optional SEG7_DP_EN adds a per-digit decimal-point mask input.
module seg7_number_display #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SIGNED     = 1,
  parameter int unsigned BLANK_LZ   = 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    load,
  input  logic [DATA_W-1:0]       data,
  input  logic                    hex_mode,
`ifdef SEG7_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp_mask,
`endif
  output logic                    ready,
  output logic                    overflow,
  output logic [8*NUM_DIGITS-1:0] seg_out
);

  localparam int unsigned NB    = (DATA_W * 302 + 999) / 1000 + 1;
  localparam int unsigned AVAIL = NUM_DIGITS - SIGNED;
  localparam int unsigned PD    = (NB > NUM_DIGITS) ? NB : NUM_DIGITS;
  localparam int unsigned HPW   = 4 * NUM_DIGITS;
  localparam int unsigned BPW   = 4 * PD;
  localparam int unsigned CW    = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_FORMAT} state_t;

  state_t                    state_q, state_d;
  logic [DATA_W-1:0]         shift_q, shift_d;
  logic [4*NB-1:0]           bcd_q, bcd_d, bcd_t;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      hex_q, hex_d;
  logic                      neg_q, neg_d;
  logic [8*NUM_DIGITS-1:0]   seg_q, seg_d, fmt_seg;
  logic                      ovf_q, ovf_d, fmt_ovf;
  logic                      ready_q, ready_d;
  logic [NUM_DIGITS-1:0]     dp_sel;
  logic [HPW-1:0]            hex_pad;
  logic [BPW-1:0]            bcd_pad;
  logic [3:0]                nib;
  int unsigned               msd;

`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0]     dp_q, dp_d;
  assign dp_sel = dp_q;
`else
  assign dp_sel = '0;
`endif

  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  // Display image built from the converted BCD digits or the raw hex nibbles
  always_comb begin
    hex_pad = HPW'(shift_q);
    bcd_pad = BPW'(bcd_q);
    fmt_ovf = 1'b0;
    fmt_seg = '1;
    msd     = 0;
    nib     = '0;
    if (hex_q) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
        if (hex_pad[4*i +: 4] != 4'h0) msd = i;
    end else begin
      for (int unsigned i = 0; i < PD; i++)
        if (bcd_pad[4*i +: 4] != 4'h0) begin
          if (i >= AVAIL) fmt_ovf = 1'b1;
          else            msd = i;
        end
    end
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      nib = hex_q ? hex_pad[4*i +: 4] : bcd_pad[4*i +: 4];
      fmt_seg[8*i +: 8] = glyph(nib);
      if (BLANK_LZ != 0 && i > msd) fmt_seg[8*i +: 8] = 8'hFF;
      if (!hex_q) begin
        if (fmt_ovf)                                 fmt_seg[8*i +: 8] = 8'hBF;
        else if (SIGNED != 0 && i == NUM_DIGITS - 1) fmt_seg[8*i +: 8] = neg_q ? 8'hBF : 8'hFF;
      end
      fmt_seg[8*i + 7] = ~dp_sel[i];
    end
  end

  // Next-state: accept, one add-3/shift step per edge, then a single format edge
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    neg_d   = neg_q;
    seg_d   = seg_q;
    ovf_d   = ovf_q;
    ready_d = ready_q;
    bcd_t   = bcd_q;
`ifdef SEG7_DP_EN
    dp_d    = dp_q;
`endif
    for (int unsigned i = 0; i < NB; i++)
      if (bcd_t[4*i +: 4] >= 4'd5) bcd_t[4*i +: 4] = bcd_t[4*i +: 4] + 4'd3;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (load) begin
          hex_d   = hex_mode;
          neg_d   = (SIGNED != 0) && !hex_mode && data[DATA_W-1];
          shift_d = neg_d ? (DATA_W'(~data) + DATA_W'(1)) : data;
          bcd_d   = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = hex_mode ? S_FORMAT : S_CONVERT;
`ifdef SEG7_DP_EN
          dp_d    = dp_mask;
`endif
        end
      end
      S_CONVERT: begin
        bcd_d   = {bcd_t[4*NB-2:0], shift_q[DATA_W-1]};
        shift_d = {shift_q[DATA_W-2:0], 1'b0};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W - 1)) state_d = S_FORMAT;
      end
      S_FORMAT: begin
        seg_d   = fmt_seg;
        ovf_d   = fmt_ovf;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= 1'b0;
      neg_q   <= 1'b0;
      seg_q   <= '1;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
`ifdef SEG7_DP_EN
      dp_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      neg_q   <= neg_d;
      seg_q   <= seg_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
`ifdef SEG7_DP_EN
      dp_q    <= dp_d;
`endif
    end
  end

  assign seg_out  = seg_q;
  assign ready    = ready_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seg7_number_display.sv
// Bench for seg7_number_display: 16-bit and 20-bit instances share stimulus and are
// checked every cycle against a latency/decimal-arithmetic model, plus literal expectations.
module tb_seg7_number_display;

  logic        Clk = 1'b0;
  logic        Reset_n, load, hex_mode;
  logic [19:0] data;
  logic [5:0]  dp_m;
  logic        rdy_a, ovf_a, rdy_b, ovf_b;
  logic [47:0] seg_a, seg_b;
  int          vectors = 0;
  int          miscompares = 0;
  bit          chk_en = 1'b0;

  always #10 Clk = ~Clk;

  seg7_number_display #(.NUM_DIGITS(6), .DATA_W(16), .SIGNED(1), .BLANK_LZ(1)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .load(load), .data(data[15:0]), .hex_mode(hex_mode),
`ifdef SEG7_DP_EN
    .dp_mask(dp_m),
`endif
    .ready(rdy_a), .overflow(ovf_a), .seg_out(seg_a));

  seg7_number_display #(.NUM_DIGITS(6), .DATA_W(20), .SIGNED(1), .BLANK_LZ(1)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .load(load), .data(data), .hex_mode(hex_mode),
`ifdef SEG7_DP_EN
    .dp_mask(dp_m),
`endif
    .ready(rdy_b), .overflow(ovf_b), .seg_out(seg_b));

  localparam logic [7:0] GLY [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Expected display from plain integer arithmetic on the value
  function automatic logic [47:0] model_seg(input logic [31:0] raw, input bit hx, input int dw,
                                            input logic [5:0] dpm);
    longint unsigned mask, u, mag;
    int dig [6];
    int nd;
    logic [47:0] s;
    bit neg;
    mask = (64'd1 << dw) - 64'd1;
    u = {32'd0, raw} & mask;
    s = '1;
    nd = 1;
    for (int i = 0; i < 6; i++) dig[i] = 0;
    if (hx) begin
      for (int i = 0; i < 6; i++) begin
        dig[i] = int'((u >> (4 * i)) & 64'd15);
        if (dig[i] != 0) nd = i + 1;
      end
      for (int i = 0; i < nd; i++) s[8*i +: 8] = GLY[dig[i]];
    end else begin
      neg = ((u >> (dw - 1)) & 64'd1) != 0;
      mag = neg ? (mask - u + 64'd1) : u;
      if (mag > 64'd99999) s = {6{8'hBF}};
      else begin
        for (int i = 0; i < 5; i++) begin
          dig[i] = int'(mag % 64'd10);
          mag = mag / 64'd10;
          if (dig[i] != 0) nd = i + 1;
        end
        for (int i = 0; i < nd; i++) s[8*i +: 8] = GLY[dig[i]];
        if (neg) s[47:40] = 8'hBF;
      end
    end
    for (int i = 0; i < 6; i++) if (dpm[i]) s[8*i + 7] = 1'b0;
    return s;
  endfunction

  function automatic bit model_ovf(input logic [31:0] raw, input bit hx, input int dw);
    longint unsigned mask, u, mag;
    mask = (64'd1 << dw) - 64'd1;
    u = {32'd0, raw} & mask;
    mag = (((u >> (dw - 1)) & 64'd1) != 0) ? (mask - u + 64'd1) : u;
    return !hx && (mag > 64'd99999);
  endfunction

  // Model: displayed value updates a fixed number of edges after acceptance
  logic [47:0] es [2];
  logic [47:0] ps [2];
  bit          eo [2];
  bit          po [2];
  bit          er [2];
  int          cnt [2];

  always @(posedge Clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!Reset_n) begin
        es[k] <= '1; eo[k] <= 1'b0; er[k] <= 1'b1; cnt[k] <= 0;
      end else if (cnt[k] == 0) begin
        if (load) begin
          ps[k]  <= model_seg(k == 0 ? {16'd0, data[15:0]} : {12'd0, data}, hex_mode, k == 0 ? 16 : 20, dp_m);
          po[k]  <= model_ovf(k == 0 ? {16'd0, data[15:0]} : {12'd0, data}, hex_mode, k == 0 ? 16 : 20);
          cnt[k] <= hex_mode ? 1 : ((k == 0 ? 16 : 20) + 1);
          er[k]  <= 1'b0;
        end
      end else if (cnt[k] == 1) begin
        es[k] <= ps[k]; eo[k] <= po[k]; er[k] <= 1'b1; cnt[k] <= 0;
      end else begin
        cnt[k] <= cnt[k] - 1;
      end
    end
  end

  task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      check("seg_a", seg_a, es[0]);
      check("rdy_a", 48'(rdy_a), 48'(er[0]));
      check("ovf_a", 48'(ovf_a), 48'(eo[0]));
      check("seg_b", seg_b, es[1]);
      check("rdy_b", 48'(rdy_b), 48'(er[1]));
      check("ovf_b", 48'(ovf_b), 48'(eo[1]));
    end
  end

  task automatic start(input logic [19:0] d, input bit hx, input logic [5:0] dpm);
    load = 1'b1; data = d; hex_mode = hx; dp_m = dpm;
    @(negedge Clk);
    load = 1'b0;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 40; k++) begin
      if (rdy_a && rdy_b) break;
      @(negedge Clk);
    end
    check("ready_timeout", 48'(rdy_a & rdy_b), 48'd1);
  endtask

  task automatic run(input logic [19:0] d, input bit hx, input logic [5:0] dpm);
    start(d, hx, dpm);
    wait_ready();
  endtask

  initial begin
    Reset_n = 1'b0; load = 1'b0; hex_mode = 1'b0; data = '0; dp_m = '0;
    @(posedge Clk);
    @(negedge Clk);
    check("reset_seg", seg_a, 48'hFFFFFFFFFFFF);
    check("reset_rdy", 48'(rdy_a), 48'd1);
    check("reset_ovf", 48'(ovf_a), 48'd0);
    chk_en = 1'b1;
    Reset_n = 1'b1;
    @(negedge Clk);

    start(20'd1234, 1'b0, 6'd0);
    check("busy_after_accept", 48'(rdy_a), 48'd0);
    wait_ready();
    check("dec_1234", seg_a, 48'hFFFFF9A4B099);
    check("dec_1234_b", seg_b, 48'hFFFFF9A4B099);

    run(20'h0FB2E, 1'b0, 6'd0);
    check("dec_m1234", seg_a, 48'hBFFFF9A4B099);
    run(20'h08000, 1'b0, 6'd0);
    check("dec_m32768", seg_a, 48'hBFB0A4F88280);
    check("dec_m32768_ovf", 48'(ovf_a), 48'd0);
    run(20'd0, 1'b0, 6'd0);
    check("dec_zero", seg_a, 48'hFFFFFFFFFFC0);
    run(20'h0BEEF, 1'b1, 6'd0);
    check("hex_beef", seg_a, 48'hFFFF8386868E);
    check("hex_beef_ovf", 48'(ovf_a), 48'd0);
    run(20'd524287, 1'b0, 6'd0);
    check("b_ovf_seg", seg_b, 48'hBFBFBFBFBFBF);
    check("b_ovf_flag", 48'(ovf_b), 48'd1);
    check("a_minus1", seg_a, 48'hBFFFFFFFFFF9);
    run(20'd7, 1'b0, 6'd0);
    check("b_seven", seg_b, 48'hFFFFFFFFFFF8);
    check("b_seven_ovf", 48'(ovf_b), 48'd0);

    start(20'd1234, 1'b0, 6'd0);
    repeat (4) @(negedge Clk);
    start(20'd99, 1'b0, 6'd0);
    wait_ready();
    check("ignored_load", seg_a, 48'hFFFFF9A4B099);

    start(20'd7, 1'b0, 6'd0);
    repeat (7) @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    check("midreset_seg", seg_a, 48'hFFFFFFFFFFFF);
    check("midreset_rdy", 48'(rdy_a), 48'd1);
    @(negedge Clk);

`ifdef SEG7_DP_EN
    run(20'd1234, 1'b0, 6'b000100);
    check("dp_digit2", 48'(seg_a[23:16]), 48'h24);
    check("dp_full", seg_a, 48'hFFFFF924B099);
`endif

    run(20'd3, 1'b0, 6'd0);
    check("dec_3", seg_a, 48'hFFFFFFFFFFB0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
